// File: rtl/seg7_defs_pkg.sv
// rtl/seg7_defs_pkg.sv - shared active-low 7-segment patterns and BCD digit constants
//
// Purpose: one place for the {g,f,e,d,c,b,a} active-low digit patterns used by
// every display block, plus the BCD digit ceiling and a decode helper.
// Ports: none (package).
package seg7_defs;

   localparam logic [6:0] SEG_0   = 7'h40;
   localparam logic [6:0] SEG_1   = 7'h79;
   localparam logic [6:0] SEG_2   = 7'h24;
   localparam logic [6:0] SEG_3   = 7'h30;
   localparam logic [6:0] SEG_4   = 7'h19;
   localparam logic [6:0] SEG_5   = 7'h12;
   localparam logic [6:0] SEG_6   = 7'h02;
   localparam logic [6:0] SEG_7   = 7'h78;
   localparam logic [6:0] SEG_8   = 7'h00;
   localparam logic [6:0] SEG_9   = 7'h10;
   localparam logic [6:0] SEG_OFF = 7'h7F;

   localparam logic [3:0] BCD_9   = 4'd9;

   // Non-BCD codes blank the digit rather than show garbage.
   function automatic logic [6:0] seg7_decode(input logic [3:0] digit);
      case (digit)
         4'd0:    seg7_decode = SEG_0;
         4'd1:    seg7_decode = SEG_1;
         4'd2:    seg7_decode = SEG_2;
         4'd3:    seg7_decode = SEG_3;
         4'd4:    seg7_decode = SEG_4;
         4'd5:    seg7_decode = SEG_5;
         4'd6:    seg7_decode = SEG_6;
         4'd7:    seg7_decode = SEG_7;
         4'd8:    seg7_decode = SEG_8;
         4'd9:    seg7_decode = SEG_9;
         default: seg7_decode = SEG_OFF;
      endcase
   endfunction

endpackage

// File: rtl/bcd_up_counter_2d_digit.sv
// rtl/bcd_up_counter_2d_digit.sv - one BCD digit register that counts up and wraps at a given value
//
// Purpose: single decade (or shorter) digit. Load has priority over increment.
// Ports:
//   clk         in   clock
//   reset       in   synchronous active-low clear
//   inc         in   advance by one (wraps to 0 when at_wrap)
//   load        in   preset digit from load_digit
//   load_digit  in 4 preset value
//   wrap_at     in 4 value after which the digit returns to 0
//   digit       out 4 registered digit
//   at_wrap     out  digit currently equals wrap_at
module bcd_digit_up (
   input  logic       clk,
   input  logic       reset,
   input  logic       inc,
   input  logic       load,
   input  logic [3:0] load_digit,
   input  logic [3:0] wrap_at,
   output logic [3:0] digit,
   output logic       at_wrap
);

   assign at_wrap = (digit == wrap_at);

   always_ff @(posedge clk) begin
      if (!reset) begin
         digit <= 4'd0;
      end else if (load) begin
         digit <= load_digit;
      end else if (inc) begin
         digit <= at_wrap ? 4'd0 : digit + 4'd1;
      end
   end

endmodule

// File: rtl/bcd_up_counter_2d.sv
// rtl/bcd_up_counter_2d.sv - two-digit BCD up counter with prescaler tick, preset load and 7-seg outputs
//
// Purpose: counts 00..MAX_BCD on an internal prescaler tick, wraps to 00 with a
// one-cycle carry, accepts validated BCD presets, drives two active-low digits.
// Ports:
//   clk            in    system clock
//   reset          in    synchronous active-low clear of all state
//   enable         in    count on tick when 1, hold when 0
//   load           in    one-cycle preset request
//   load_val       in  8 BCD preset {tens, ones}
//   count_ones     out 4 ones digit
//   count_tens     out 4 tens digit
//   carry          out   one-cycle pulse on MAX_BCD -> 00
//   load_err       out   one-cycle pulse when a preset is rejected
//   tick           out   one-cycle prescaler tick
//   seg7_out       out 7 ones digit, active-low {g,f,e,d,c,b,a}
//   seg7_tens_out  out 7 tens digit, same encoding
module bcd_up_counter_2d
   import seg7_defs::*;
#(
   parameter int unsigned DIV_EXP  = 22,
   parameter logic [7:0]  MAX_BCD  = 8'h99,
   parameter bit          BLANK_LZ = 1'b0
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       load,
   input  logic [7:0] load_val,
   output logic [3:0] count_ones,
   output logic [3:0] count_tens,
   output logic       carry,
   output logic       load_err,
   output logic       tick,
   output logic [6:0] seg7_out,
   output logic [6:0] seg7_tens_out
);

   localparam logic [3:0] MAX_ONES = MAX_BCD[3:0];
   localparam logic [3:0] MAX_TENS = MAX_BCD[7:4];
   localparam logic [DIV_EXP-1:0] PRESC_ONE = {{(DIV_EXP-1){1'b0}}, 1'b1};

   logic [DIV_EXP-1:0] prescaler;
   logic               load_ok;
   logic               do_load;
   logic               step;
   logic [3:0]         ones_wrap_at;
   logic               ones_at_wrap;
   logic               tens_at_wrap;
   logic               terminal;

   // Free-running divider; tick is the registered all-ones detect, so it is
   // high for the cycle after the prescaler sits at all-ones.
   always_ff @(posedge clk) begin
      if (!reset) begin
         prescaler <= '0;
         tick      <= 1'b0;
      end else begin
         prescaler <= prescaler + PRESC_ONE;
         tick      <= &prescaler;
      end
   end

   // Both nibbles must be decimal and the whole value within range. For valid
   // BCD a plain binary compare orders the same as the decimal value.
   assign load_ok = (load_val[3:0] <= BCD_9) && (load_val[7:4] <= BCD_9) &&
                    (load_val <= MAX_BCD);
   assign do_load = load && load_ok;

   // A load request (accepted or not) suppresses the step on that edge.
   assign step = tick && enable && !load;

   // In the top decade the ones digit wraps at MAX_BCD's ones, which makes the
   // terminal count a simultaneous wrap of both digits.
   assign ones_wrap_at = (count_tens == MAX_TENS) ? MAX_ONES : BCD_9;
   assign terminal     = ones_at_wrap && tens_at_wrap;

   bcd_digit_up u_ones (
      .clk        (clk),
      .reset      (reset),
      .inc        (step),
      .load       (do_load),
      .load_digit (load_val[3:0]),
      .wrap_at    (ones_wrap_at),
      .digit      (count_ones),
      .at_wrap    (ones_at_wrap)
   );

   bcd_digit_up u_tens (
      .clk        (clk),
      .reset      (reset),
      .inc        (step && ones_at_wrap),
      .load       (do_load),
      .load_digit (load_val[7:4]),
      .wrap_at    (MAX_TENS),
      .digit      (count_tens),
      .at_wrap    (tens_at_wrap)
   );

   always_ff @(posedge clk) begin
      if (!reset) begin
         carry    <= 1'b0;
         load_err <= 1'b0;
      end else begin
         carry    <= step && terminal;
         load_err <= load && !load_ok;
      end
   end

   assign seg7_out      = seg7_decode(count_ones);
   assign seg7_tens_out = (BLANK_LZ && (count_tens == 4'd0)) ? SEG_OFF
                                                             : seg7_decode(count_tens);

endmodule

// File: tb/tb_bcd_up_counter_2d.sv
// tb/tb_bcd_up_counter_2d.sv - scoreboard bench for bcd_up_counter_2d (two parameterisations)
module tb_bcd_up_counter_2d;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic       rst [2];
   logic       en  [2];
   logic       ld  [2];
   logic [7:0] lv  [2];

   logic [3:0] o_ones  [2];
   logic [3:0] o_tens  [2];
   logic       o_carry [2];
   logic       o_lerr  [2];
   logic       o_tick  [2];
   logic [6:0] o_seg   [2];
   logic [6:0] o_segt  [2];

   bcd_up_counter_2d #(.DIV_EXP(2), .MAX_BCD(8'h99), .BLANK_LZ(1'b0)) dut0 (
      .clk(clk), .reset(rst[0]), .enable(en[0]), .load(ld[0]), .load_val(lv[0]),
      .count_ones(o_ones[0]), .count_tens(o_tens[0]), .carry(o_carry[0]),
      .load_err(o_lerr[0]), .tick(o_tick[0]), .seg7_out(o_seg[0]),
      .seg7_tens_out(o_segt[0])
   );

   bcd_up_counter_2d #(.DIV_EXP(2), .MAX_BCD(8'h59), .BLANK_LZ(1'b1)) dut1 (
      .clk(clk), .reset(rst[1]), .enable(en[1]), .load(ld[1]), .load_val(lv[1]),
      .count_ones(o_ones[1]), .count_tens(o_tens[1]), .carry(o_carry[1]),
      .load_err(o_lerr[1]), .tick(o_tick[1]), .seg7_out(o_seg[1]),
      .seg7_tens_out(o_segt[1])
   );

   typedef struct {
      int         cyc;
      int         d;
      string      nm;
      bit         full;
      logic [7:0] cnt;
      logic       cy;
      logic       le;
      logic       tk;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   function automatic logic [7:0] maxv(input int d);
      return (d == 0) ? 8'h99 : 8'h59;
   endfunction

   function automatic logic [6:0] seg_of(input logic [3:0] v);
      case (v)
         4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
         4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
         4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
         4'd9: return 7'h10;  default: return 7'h7F;
      endcase
   endfunction

   // Monitor: pops every expectation due in the current cycle.
   exp_t       me;
   logic [7:0] acnt;
   logic [6:0] es, et;
   logic       bad;
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         me   = q.pop_front();
         acnt = {o_tens[me.d], o_ones[me.d]};
         es   = seg_of(me.cnt[3:0]);
         et   = (me.d == 1 && me.cnt[7:4] == 4'd0) ? 7'h7F : seg_of(me.cnt[7:4]);
         n_tests++;
         bad = (me.cyc != cyc) || (acnt !== me.cnt) || (o_carry[me.d] !== me.cy) ||
               (o_lerr[me.d] !== me.le);
         if (me.full)
            bad = bad || (o_tick[me.d] !== me.tk) || (o_seg[me.d] !== es) ||
                  (o_segt[me.d] !== et);
         if (bad) begin
            n_fail++;
            $display("FAIL %s dut%0d cyc%0d: got cnt=%h carry=%b lerr=%b tick=%b seg=%h/%h, want cnt=%h carry=%b lerr=%b tick=%b seg=%h/%h (due cyc%0d)",
                     me.nm, me.d, cyc, acnt, o_carry[me.d], o_lerr[me.d], o_tick[me.d],
                     o_segt[me.d], o_seg[me.d], me.cnt, me.cy, me.le, me.tk, et, es, me.cyc);
         end
      end
   end

   // Reference state per instance.
   int         mp [2];
   logic       mt [2];
   logic [7:0] mc [2];

   task automatic expect_cnt(input int d, input string nm, input logic [7:0] c,
                             input logic cy, input logic le);
      q.push_back('{cyc + 1, d, nm, 1'b0, c, cy, le, 1'b0});
   endtask

   // Advance the reference by one edge for both instances, queue the expected
   // post-edge outputs, then move to the next sampling point.
   task automatic cycle();
      for (int d = 0; d < 2; d++) begin
         logic cy, le, ntk;
         cy = 1'b0;
         le = 1'b0;
         if (!rst[d]) begin
            mp[d] = 0;
            mt[d] = 1'b0;
            mc[d] = 8'h00;
         end else begin
            ntk = (mp[d] == 3);
            if (ld[d]) begin
               if (lv[d][3:0] <= 4'd9 && lv[d][7:4] <= 4'd9 && lv[d] <= maxv(d))
                  mc[d] = lv[d];
               else
                  le = 1'b1;
            end else if (mt[d] && en[d]) begin
               if (mc[d] == maxv(d)) begin
                  mc[d] = 8'h00;
                  cy    = 1'b1;
               end else if (mc[d][3:0] == 4'd9) begin
                  mc[d] = {mc[d][7:4] + 4'd1, 4'd0};
               end else begin
                  mc[d] = mc[d] + 8'd1;
               end
            end
            mt[d] = ntk;
            mp[d] = (mp[d] + 1) % 4;
         end
         q.push_back('{cyc + 1, d, "model", 1'b1, mc[d], cy, le, mt[d]});
      end
      @(negedge clk);
   endtask

   task automatic wait_tick(input int d);
      for (int k = 0; k < 8 && !mt[d]; k++) cycle();
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b0; en[d] = 1'b0; ld[d] = 1'b1; lv[d] = 8'h47;
         mp[d] = 0; mt[d] = 1'b0; mc[d] = 8'h00;
      end
      @(negedge clk);

      // 1: reset with load asserted
      expect_cnt(0, "reset_with_load", 8'h00, 1'b0, 1'b0);
      expect_cnt(1, "reset_with_load", 8'h00, 1'b0, 1'b0);
      cycle();
      cycle();

      // 2: 100 steps from 00; step k lands on edge 4k+1 after release
      for (int d = 0; d < 2; d++) begin
         rst[d] = 1'b1; ld[d] = 1'b0;
      end
      en[0] = 1'b1;
      repeat (399) cycle();
      expect_cnt(0, "reached_99", 8'h99, 1'b0, 1'b0);
      cycle();
      expect_cnt(0, "wrap_99_00_carry", 8'h00, 1'b1, 1'b0);
      cycle();
      expect_cnt(0, "carry_one_cycle", 8'h00, 1'b0, 1'b0);
      cycle();
      en[0] = 1'b0;
      cycle();

      // 3: loads
      ld[0] = 1'b1; lv[0] = 8'h47;
      expect_cnt(0, "load_47", 8'h47, 1'b0, 1'b0);
      cycle();
      lv[0] = 8'h3A;
      expect_cnt(0, "load_3A_rejected", 8'h47, 1'b0, 1'b1);
      cycle();
      ld[0] = 1'b0;
      expect_cnt(0, "load_err_one_cycle", 8'h47, 1'b0, 1'b0);
      cycle();
      ld[1] = 1'b1; lv[1] = 8'h60;
      expect_cnt(1, "load_60_over_max59", 8'h00, 1'b0, 1'b1);
      cycle();
      lv[1] = 8'h59;
      expect_cnt(1, "load_59_at_max", 8'h59, 1'b0, 1'b0);
      cycle();

      // 4: MAX_BCD=59 wrap from 58
      lv[1] = 8'h58;
      expect_cnt(1, "load_58", 8'h58, 1'b0, 1'b0);
      cycle();
      ld[1] = 1'b0;
      wait_tick(1);
      en[1] = 1'b1;
      expect_cnt(1, "step_58_59", 8'h59, 1'b0, 1'b0);
      cycle();
      repeat (3) cycle();
      expect_cnt(1, "wrap_59_00_carry", 8'h00, 1'b1, 1'b0);
      cycle();
      en[1] = 1'b0;
      ld[1] = 1'b1; lv[1] = 8'h15;
      expect_cnt(1, "load_15_tens_shown", 8'h15, 1'b0, 1'b0);
      cycle();
      ld[1] = 1'b0;

      // 5: hold with enable low, then load coincident with tick
      ld[0] = 1'b1; lv[0] = 8'h23;
      expect_cnt(0, "load_23", 8'h23, 1'b0, 1'b0);
      cycle();
      ld[0] = 1'b0;
      repeat (40) cycle();
      expect_cnt(0, "hold_23_10_ticks", 8'h23, 1'b0, 1'b0);
      cycle();
      ld[0] = 1'b1; lv[0] = 8'h98;
      expect_cnt(0, "load_98", 8'h98, 1'b0, 1'b0);
      cycle();
      ld[0] = 1'b0;
      wait_tick(0);
      ld[0] = 1'b1; lv[0] = 8'h99; en[0] = 1'b1;
      expect_cnt(0, "load_beats_tick", 8'h99, 1'b0, 1'b0);
      cycle();
      ld[0] = 1'b0; en[0] = 1'b0;
      expect_cnt(0, "no_step_after_load", 8'h99, 1'b0, 1'b0);
      cycle();

      // 6: reset during tick at 99
      wait_tick(0);
      rst[0] = 1'b0; en[0] = 1'b1;
      expect_cnt(0, "reset_beats_tick", 8'h00, 1'b0, 1'b0);
      cycle();
      rst[0] = 1'b1; en[0] = 1'b0;
      expect_cnt(0, "after_reset_no_carry", 8'h00, 1'b0, 1'b0);
      cycle();
      repeat (6) cycle();

      @(negedge clk);
      #1;
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL queue_drained: %0d entries left, want 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
